// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: funct codes, FSM states and op kinds.
package mdu_pkg;

   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

   typedef enum logic {
      OP_MUL = 1'b0,
      OP_DIV = 1'b1
   } op_kind_e;

endpackage

// File: rtl/mdu_step_core.sv
// One iteration of the multiply (shift-add) or restoring divide (shift-subtract) datapath.
// Divide step is only built when MDU_DIV_EN is defined.
module mdu_step_core
   import mdu_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic [2*NB_DATA:0]  acc_i,
   input  logic [NB_DATA-1:0]  operand_i,
   input  op_kind_e            kind_i,
   output logic [2*NB_DATA:0]  acc_o
);

   // Multiply: upper half (with carry bit) accumulates, whole word shifts right
   logic [NB_DATA:0]   mul_sum;
   logic [2*NB_DATA:0] mul_next;

   assign mul_sum  = acc_i[0] ? (acc_i[2*NB_DATA:NB_DATA] + {1'b0, operand_i})
                              : acc_i[2*NB_DATA:NB_DATA];
   assign mul_next = {1'b0, mul_sum, acc_i[NB_DATA-1:1]};

`ifdef MDU_DIV_EN
   // Divide: {remainder, dividend} shifts left, quotient bits enter at bit 0
   logic [NB_DATA:0]   div_rem;
   logic [NB_DATA:0]   div_diff;
   logic               div_ge;
   logic [2*NB_DATA:0] div_next;

   assign div_rem  = acc_i[2*NB_DATA-1:NB_DATA-1];
   assign div_diff = div_rem - {1'b0, operand_i};
   assign div_ge   = (div_rem >= {1'b0, operand_i});
   assign div_next = div_ge ? {div_diff, acc_i[NB_DATA-2:0], 1'b1}
                            : {acc_i[2*NB_DATA-1:0], 1'b0};

   assign acc_o = (kind_i == OP_DIV) ? div_next : mul_next;
`else
   assign acc_o = (kind_i == OP_MUL) ? mul_next : acc_i;
`endif

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers and pipeline stall request.
// Define MDU_DIV_EN to build DIV/DIVU support; otherwise divide functs are ignored.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int NB_DATA    = 32,
   parameter int BITS_FUNCT = 6
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_valid,
   input  logic [BITS_FUNCT-1:0] i_funct,
   input  logic [NB_DATA-1:0]    i_op_a,
   input  logic [NB_DATA-1:0]    i_op_b,
   input  logic                  i_flush,
   output logic                  o_stall,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [NB_DATA-1:0]    o_hi,
   output logic [NB_DATA-1:0]    o_lo,
   output logic [NB_DATA-1:0]    o_mf_data
);

   // state   | meaning
   // IDLE    | accepts MULT/DIV, services MT/MF
   // RUN     | one shift-add / shift-subtract step per cycle, NB_DATA steps
   // FIX     | sign fixup, write HI/LO, pulse done

   localparam int               CNT_W    = $clog2(NB_DATA);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB_DATA - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*NB_DATA:0] acc_q, acc_d, acc_step;
   logic [NB_DATA-1:0] opb_q, opb_d;
   op_kind_e           kind_q, kind_d;
   logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic [NB_DATA-1:0] hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;

   logic is_mul, is_div, is_mf, is_mt, is_signed, accept;
   logic sgn_a, sgn_b, neg_res;
   logic [NB_DATA-1:0]   mag_a, mag_b;
   logic [2*NB_DATA-1:0] prod_fix;

   assign is_mul    = (i_funct == FUNCT_MULT) || (i_funct == FUNCT_MULTU);
`ifdef MDU_DIV_EN
   assign is_div    = (i_funct == FUNCT_DIV) || (i_funct == FUNCT_DIVU);
`else
   assign is_div    = 1'b0;
`endif
   assign is_mf     = (i_funct == FUNCT_MFHI) || (i_funct == FUNCT_MFLO);
   assign is_mt     = (i_funct == FUNCT_MTHI) || (i_funct == FUNCT_MTLO);
   assign is_signed = (i_funct == FUNCT_MULT) || (i_funct == FUNCT_DIV);

   assign o_stall = i_valid & (is_mul | is_div | is_mf | is_mt) & (state_q != ST_IDLE);
   assign accept  = i_valid & (is_mul | is_div) & ~o_stall & ~i_flush & (state_q == ST_IDLE);

   assign sgn_a = is_signed & i_op_a[NB_DATA-1];
   assign sgn_b = is_signed & i_op_b[NB_DATA-1];
   assign mag_a = sgn_a ? -i_op_a : i_op_a;
   assign mag_b = sgn_b ? -i_op_b : i_op_b;

   assign neg_res  = sign_a_q ^ sign_b_q;
   assign prod_fix = neg_res ? -acc_q[2*NB_DATA-1:0] : acc_q[2*NB_DATA-1:0];

`ifdef MDU_DIV_EN
   logic               div0_q, div0_d;
   logic [NB_DATA-1:0] a_raw_q, a_raw_d;
   logic [NB_DATA-1:0] quo_fix, rem_fix;

   assign quo_fix = neg_res  ? -acc_q[NB_DATA-1:0] : acc_q[NB_DATA-1:0];
   assign rem_fix = sign_a_q ? -acc_q[2*NB_DATA-1:NB_DATA] : acc_q[2*NB_DATA-1:NB_DATA];
`endif

   mdu_step_core #(
      .NB_DATA (NB_DATA)
   ) u_step (
      .acc_i     (acc_q),
      .operand_i (opb_q),
      .kind_i    (kind_q),
      .acc_o     (acc_step)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      kind_d   = kind_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
`ifdef MDU_DIV_EN
      div0_d   = div0_q;
      a_raw_d  = a_raw_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d  = ST_RUN;
               cnt_d    = '0;
               acc_d    = {{(NB_DATA+1){1'b0}}, mag_a};
               opb_d    = mag_b;
               kind_d   = is_div ? OP_DIV : OP_MUL;
               sign_a_d = sgn_a;
               sign_b_d = sgn_b;
`ifdef MDU_DIV_EN
               div0_d   = is_div & (i_op_b == '0);
               a_raw_d  = i_op_a;
`endif
            end else if (i_valid && i_funct == FUNCT_MTHI) begin
               hi_d = i_op_a;
            end else if (i_valid && i_funct == FUNCT_MTLO) begin
               lo_d = i_op_a;
            end
         end
         ST_RUN: begin
            if (i_flush) begin
               state_d = ST_IDLE;
            end else begin
               acc_d = acc_step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            if (!i_flush) begin
               done_d       = 1'b1;
               {hi_d, lo_d} = prod_fix;
`ifdef MDU_DIV_EN
               if (kind_q == OP_DIV) begin
                  // divide-by-zero bypasses the fixup entirely
                  lo_d = div0_q ? '1      : quo_fix;
                  hi_d = div0_q ? a_raw_q : rem_fix;
               end
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         kind_q   <= OP_MUL;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
`ifdef MDU_DIV_EN
         div0_q   <= 1'b0;
         a_raw_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         kind_q   <= kind_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
`ifdef MDU_DIV_EN
         div0_q   <= div0_d;
         a_raw_q  <= a_raw_d;
`endif
      end
   end

   assign o_busy    = (state_q != ST_IDLE);
   assign o_done    = done_q;
   assign o_hi      = hi_q;
   assign o_lo      = lo_q;
   assign o_mf_data = (i_funct == FUNCT_MFHI) ? hi_q :
                      (i_funct == FUNCT_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: random and directed MULT/DIV/MT/MF traffic against an arithmetic model.
module tb_mult_div_unit;
   import mdu_pkg::*;

   localparam int LAT = 33;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_valid = 1'b0;
   logic [5:0]  i_funct = '0;
   logic [31:0] i_op_a = '0;
   logic [31:0] i_op_b = '0;
   logic        i_flush = 1'b0;
   logic        o_stall, o_busy, o_done;
   logic [31:0] o_hi, o_lo, o_mf_data;

   mult_div_unit #(.NB_DATA(32), .BITS_FUNCT(6)) dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_valid   (i_valid),
      .i_funct   (i_funct),
      .i_op_a    (i_op_a),
      .i_op_b    (i_op_b),
      .i_flush   (i_flush),
      .o_stall   (o_stall),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_hi      (o_hi),
      .o_lo      (o_lo),
      .o_mf_data (o_mf_data)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          t0;
   } exp_t;

   exp_t        sb_q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] mhi = '0;
   logic [31:0] mlo = '0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference result {HI, LO} from plain integer arithmetic
   function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sbv, q, r;
      logic [63:0] res;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      res = '0;
      case (f)
         FUNCT_MULT:  res = sa * sbv;
         FUNCT_MULTU: res = {32'b0, a} * {32'b0, b};
         FUNCT_DIV: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sbv;
               r = sa % sbv;
               res = {r[31:0], q[31:0]};
            end
         end
         FUNCT_DIVU: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge i_clk) begin
      if (i_reset_n && o_done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 64'(o_done), 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("result_hi", 64'(o_hi), 64'(e.hi));
            chk("result_lo", 64'(o_lo), 64'(e.lo));
            chk("latency", 64'(cyc - e.t0), 64'(LAT));
         end
      end
   end

   task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit push);
      logic [63:0] r;
      @(posedge i_clk); #1;
      i_valid = 1'b1; i_funct = f; i_op_a = a; i_op_b = b;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      if (push) begin
         r = model(f, a, b);
         sb_q.push_back('{hi: r[63:32], lo: r[31:0], t0: cyc});
         mhi = r[63:32];
         mlo = r[31:0];
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (o_busy && n < 200) begin
         @(posedge i_clk); #1;
         n++;
      end
      chk("idle_timeout", 64'(o_busy), 64'd0);
   endtask

   task automatic mt(input logic [5:0] f, input logic [31:0] v);
      start_op(f, v, 32'h0, 1'b0);
      if (f == FUNCT_MTHI) begin
         mhi = v;
         chk("mthi", 64'(o_hi), 64'(v));
      end else begin
         mlo = v;
         chk("mtlo", 64'(o_lo), 64'(v));
      end
   endtask

   task automatic mf_check(input logic [5:0] f, input logic [31:0] exp);
      @(posedge i_clk); #1;
      i_valid = 1'b1; i_funct = f;
      @(negedge i_clk);
      chk((f == FUNCT_MFHI) ? "mfhi" : "mflo", 64'(o_mf_data), 64'(exp));
      @(posedge i_clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      start_op(f, a, b, 1'b1);
      wait_idle();
      mf_check(FUNCT_MFHI, mhi);
      mf_check(FUNCT_MFLO, mlo);
   endtask

   initial begin
      logic [5:0] fl [4];
      int nf, n;
      fl[0] = FUNCT_MULT; fl[1] = FUNCT_MULTU; fl[2] = FUNCT_DIV; fl[3] = FUNCT_DIVU;
`ifdef MDU_DIV_EN
      nf = 4;
`else
      nf = 2;
`endif

      repeat (3) @(posedge i_clk);
      #1;
      chk("reset_hi", 64'(o_hi), 64'd0);
      chk("reset_lo", 64'(o_lo), 64'd0);
      chk("reset_busy", 64'(o_busy), 64'd0);
      chk("reset_done", 64'(o_done), 64'd0);
      i_reset_n = 1'b1;

      run_op(FUNCT_MULT,  32'hFFFF_FFFE, 32'd3);
      run_op(FUNCT_MULTU, 32'hFFFF_FFFE, 32'd3);
`ifdef MDU_DIV_EN
      run_op(FUNCT_DIV,  32'hFFFF_FFF9, 32'd2);
      run_op(FUNCT_DIVU, 32'd7, 32'd0);
      run_op(FUNCT_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
      run_op(FUNCT_DIV,  32'hFFFF_FFF0, 32'd0);
      run_op(FUNCT_DIV,  32'd7, 32'hFFFF_FFFE);
`endif

      // Dependent MFLO held from the cycle after accept
      start_op(FUNCT_MULT, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
      i_valid = 1'b1; i_funct = FUNCT_MFLO;
      n = 0;
      @(negedge i_clk);
      while (o_stall && n < 100) begin
         n++;
         @(negedge i_clk);
      end
      chk("stall_cycles", 64'(n), 64'(LAT));
      chk("mf_after_stall", 64'(o_mf_data), 64'(mlo));
      @(posedge i_clk); #1;
      i_valid = 1'b0;

      // Flush during RUN
      mt(FUNCT_MTHI, 32'h11);
      mt(FUNCT_MTLO, 32'h22);
      start_op(FUNCT_MULT, 32'd100, 32'd200, 1'b0);
      repeat (9) @(posedge i_clk);
      #1;
      i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      chk("flush_busy", 64'(o_busy), 64'd0);
      chk("flush_hi", 64'(o_hi), 64'h11);
      chk("flush_lo", 64'(o_lo), 64'h22);
      repeat (40) @(posedge i_clk);

      // Flush on the accept cycle drops the op
      @(posedge i_clk); #1;
      i_valid = 1'b1; i_funct = FUNCT_MULTU; i_op_a = 32'd9; i_op_b = 32'd9; i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_flush = 1'b0;
      chk("flush_accept_busy", 64'(o_busy), 64'd0);

`ifndef MDU_DIV_EN
      @(posedge i_clk); #1;
      i_valid = 1'b1; i_funct = FUNCT_DIV; i_op_a = 32'd8; i_op_b = 32'd2;
      @(negedge i_clk);
      chk("nodiv_stall", 64'(o_stall), 64'd0);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      chk("nodiv_busy", 64'(o_busy), 64'd0);
      repeat (3) @(posedge i_clk);
      #1;
      chk("nodiv_busy_later", 64'(o_busy), 64'd0);
      chk("nodiv_hi", 64'(o_hi), 64'(mhi));
      chk("nodiv_lo", 64'(o_lo), 64'(mlo));
`endif

      // Asynchronous reset mid-RUN
      start_op(FUNCT_MULT, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0);
      repeat (5) @(posedge i_clk);
      #1;
      i_reset_n = 1'b0;
      #1;
      chk("rst_hi", 64'(o_hi), 64'd0);
      chk("rst_lo", 64'(o_lo), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      mhi = '0; mlo = '0;
      @(posedge i_clk); #1;
      i_reset_n = 1'b1;
      run_op(FUNCT_MULT, 32'd5, 32'd6);

      for (int i = 0; i < 24; i++) begin
         logic [31:0] a, b;
         a = rnd_op();
         b = rnd_op();
         if ($urandom_range(0, 3) == 0) begin
            mt(($urandom_range(0, 1) == 0) ? FUNCT_MTHI : FUNCT_MTLO, $urandom());
         end
         run_op(fl[$urandom_range(0, nf - 1)], a, b);
      end

      repeat (5) @(posedge i_clk);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
